matc_writer: RTL

- Write-side controller for the 8x8 matrix-multiply datapath. Accepts the result-element stream from the MAC array in row-major order and narrows each accumulator value to RAM word width.
- Issues single-port RAM writes in column-major layout (addr = col*N + row), matching the layout used by the read-side operand RAMs.
- A start/done handshake brackets each full N*N matrix store.

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matc_narrow.sv | 27 ++
 rtl/matc_writer.sv | 111 +++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants, write-side FSM states and RAM layout helper for the 8x8 matmul.
// Contents:
//   MAT_N, ACC_W, DATA_W, ADDR_W  - matrix dimension and datapath widths
//   wr_state_t                    - matc_writer FSM states
//   colmaj_addr(row, col)         - column-major RAM address (col*MAT_N + row)
package matmul_pkg;

    localparam int MAT_N  = 8;
    localparam int ACC_W  = 19;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {IDLE, ACCEPT, FLUSH, DONE} wr_state_t;

    function automatic logic [ADDR_W-1:0] colmaj_addr(
        input logic [ADDR_W-1:0] row,
        input logic [ADDR_W-1:0] col
    );
        return ADDR_W'(col * MAT_N + row);
    endfunction

endpackage

// File: rtl/matc_narrow.sv
// matc_narrow: combinational conversion of a signed accumulator value to a signed RAM word.
// Ports:
//   in_i   in  ACC_W   signed accumulator value
//   out_o  out DATA_W  signed narrowed value
// Build option MATC_WRITER_SAT_EN: saturate to the DATA_W range instead of truncating.
module matc_narrow #(
    parameter int ACC_W  = matmul_pkg::ACC_W,
    parameter int DATA_W = matmul_pkg::DATA_W
) (
    input  logic signed [ACC_W-1:0]  in_i,
    output logic signed [DATA_W-1:0] out_o
);
`ifdef MATC_WRITER_SAT_EN
    localparam logic signed [ACC_W-1:0] HI = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] LO = -HI - ACC_W'(1);
    always_comb begin
        out_o = (in_i > HI) ? DATA_W'(HI) : (in_i < LO) ? DATA_W'(LO) : in_i[DATA_W-1:0];
    end
`else
    // Two's-complement wrap: the upper accumulator bits are simply dropped.
    logic unused_hi;
    assign unused_hi = ^in_i[ACC_W-1:DATA_W];
    always_comb begin
        out_o = in_i[DATA_W-1:0];
    end
`endif
endmodule

// File: rtl/matc_writer.sv
// matc_writer: stores a row-major result stream into RAM in column-major layout, narrowed to RAM width.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            pulse; begins a matrix store when idle
//   in_valid/in_ready/in_data   result element handshake (row-major, ACC_W signed)
//   ram_we/ram_addr/ram_wdata   registered RAM write port (addr = col*N + row)
//   busy             store in progress (ACCEPT or FLUSH)
//   done             one-cycle pulse after the last write has been issued
//   count            elements accepted in the current store
// Build option MATC_WRITER_SAT_EN: saturating narrowing (see matc_narrow).
module matc_writer #(
    parameter int N      = matmul_pkg::MAT_N,
    parameter int ACC_W  = matmul_pkg::ACC_W,
    parameter int DATA_W = matmul_pkg::DATA_W,
    parameter int ADDR_W = matmul_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [ACC_W-1:0]  in_data,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic signed [DATA_W-1:0] ram_wdata,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        count
);
    import matmul_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(N * N - 1);

    wr_state_t                state_q;
    logic [ADDR_W-1:0]        row_q, col_q, count_q, row_d, col_d;
    logic                     in_ready_q, ram_we_q, busy_q, done_q;
    logic [ADDR_W-1:0]        ram_addr_q;
    logic signed [DATA_W-1:0] ram_wdata_q, narrow_d;
    logic                     accept;

    matc_narrow #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_narrow (
        .in_i  (in_data),
        .out_o (narrow_d)
    );

    // in_ready_q is high exactly while in ACCEPT.
    assign accept = in_ready_q & in_valid;

    // Row-major walk: col is the fast index; row only wraps on the final beat.
    always_comb begin
        col_d = (col_q == LAST_IDX) ? '0 : col_q + 1'b1;
        row_d = (col_q != LAST_IDX) ? row_q : (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ram_we_q <= accept;
            done_q   <= 1'b0;
            if (accept) begin
                ram_addr_q  <= colmaj_addr(row_q, col_q);
                ram_wdata_q <= narrow_d;
                row_q       <= row_d;
                col_q       <= col_d;
                count_q     <= count_q + 1'b1;
            end
            case (state_q)
                IDLE: if (start) begin
                    row_q      <= '0;
                    col_q      <= '0;
                    count_q    <= '0;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= ACCEPT;
                end
                ACCEPT: if (accept && count_q == LAST_CNT) begin
                    in_ready_q <= 1'b0;
                    state_q    <= FLUSH;
                end
                // The last write sits on the RAM port during FLUSH.
                FLUSH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule
